// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: redirect load has priority over sequential advance.
module program_counter
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        advance,
  input  logic [31:0] advance_base,
  output logic [31:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= align_pc(load_pc);
    end else if (advance) begin
      pc <= advance_base + PC_STEP;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: request-and-wait memory interface, single-entry output slot, redirect flushing.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic        Mem_Ready,
  input  logic [31:0] Mem_Data,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Stall,
  output logic [31:0] Instruction,
  output logic [31:0] Instruction_PC,
  output logic        Instruction_Valid
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  req_addr_p0;
  logic         req_raw;
  logic         capture;
  logic         latch_addr;
  logic [31:0]  instr_p1;
  logic [31:0]  pc_p1;
  logic         vld_p1;

  program_counter #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk         (Clock),
    .rst         (Reset),
    .load        (Branch_Taken),
    .load_pc     (Branch_Target),
    .advance     (capture),
    .advance_base(Mem_Addr),
    .pc          (pc)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_raw && !Mem_Ready) state_nxt = REQ;
      end
      REQ: begin
        if (Mem_Ready)         state_nxt = IDLE;
        else if (Branch_Taken) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (Mem_Ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Once a request is outstanding the address must not move, even across a redirect.
  always_comb begin
    req_raw    = 1'b0;
    Mem_Addr   = pc;
    capture    = 1'b0;
    latch_addr = 1'b0;
    case (state)
      IDLE: begin
        req_raw    = (!vld_p1 || !Stall) && !Branch_Taken;
        Mem_Addr   = pc;
        capture    = req_raw && Mem_Ready;
        latch_addr = req_raw && !Mem_Ready;
      end
      REQ: begin
        req_raw  = 1'b1;
        Mem_Addr = req_addr_p0;
        capture  = Mem_Ready && !Branch_Taken;
      end
      FLUSH: begin
        req_raw  = 1'b1;
        Mem_Addr = req_addr_p0;
      end
      default: begin
        req_raw = 1'b0;
      end
    endcase
    Mem_Req = req_raw && !Reset;
  end

  // ---- stage p0: outstanding request address ----
  always_ff @(posedge Clock) begin
    if (latch_addr) begin
      req_addr_p0 <= pc;
    end
  end

  // ---- stage p1: output slot toward decode ----
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
      pc_p1    <= 32'h0000_0000;
    end else if (Branch_Taken) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
    end else if (capture) begin
      vld_p1   <= 1'b1;
      instr_p1 <= Mem_Data;
      pc_p1    <= Mem_Addr;
    end else if (vld_p1 && !Stall) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
    end
  end

  assign Instruction       = instr_p1;
  assign Instruction_PC    = pc_p1;
  assign Instruction_Valid = vld_p1;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed table-driven bench for instruction_fetch plus hand-written reset and wrap sequences.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] D   = 32'hDEAD_BEEF;

  logic        Clock;
  logic        Reset;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic        Mem_Ready;
  logic [31:0] Mem_Data;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Stall;
  logic [31:0] Instruction;
  logic [31:0] Instruction_PC;
  logic        Instruction_Valid;

  int n_pass  = 0;
  int n_total = 0;

  instruction_fetch dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .Mem_Req          (Mem_Req),
    .Mem_Addr         (Mem_Addr),
    .Mem_Ready        (Mem_Ready),
    .Mem_Data         (Mem_Data),
    .Branch_Taken     (Branch_Taken),
    .Branch_Target    (Branch_Target),
    .Stall            (Stall),
    .Instruction      (Instruction),
    .Instruction_PC   (Instruction_PC),
    .Instruction_Valid(Instruction_Valid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        br;
    logic        stall;
    logic [31:0] data;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        valid;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic rst, input logic ready, input logic br, input logic stall,
                     input logic [31:0] data, input logic [31:0] tgt,
                     input logic req, input logic [31:0] addr, input logic [31:0] instr,
                     input logic [31:0] ipc, input logic valid);
    vec_t v;
    v.rst = rst; v.ready = ready; v.br = br; v.stall = stall; v.data = data; v.tgt = tgt;
    v.req = req; v.addr = addr; v.instr = instr; v.ipc = ipc; v.valid = valid;
    vecs.push_back(v);
  endtask

  initial begin
    Reset = 1'b1; Mem_Ready = 1'b0; Mem_Data = '0;
    Branch_Taken = 1'b0; Branch_Target = '0; Stall = 1'b0;

    //  rst rdy br stl data          tgt            req addr          instr         ipc           vld
    add(1, 0, 0, 0, 32'h0,         32'h0,         0, 32'h0,         NOP,          32'h0,        0);
    // zero-wait streaming
    add(0, 1, 0, 0, 32'h1000_0000, 32'h0,         1, 32'h0,         NOP,          32'h0,        0);
    add(0, 1, 0, 0, 32'h1000_0004, 32'h0,         1, 32'h4,         32'h1000_0000, 32'h0,       1);
    add(0, 1, 0, 0, 32'h1000_0008, 32'h0,         1, 32'h8,         32'h1000_0004, 32'h4,       1);
    // two wait cycles on 0xC
    add(0, 0, 0, 0, D,             32'h0,         1, 32'hC,         32'h1000_0008, 32'h8,       1);
    add(0, 0, 0, 0, D,             32'h0,         1, 32'hC,         NOP,          32'h8,        0);
    add(0, 1, 0, 0, 32'h1000_000C, 32'h0,         1, 32'hC,         NOP,          32'h8,        0);
    // stall four cycles with a full slot
    add(0, 1, 0, 1, D,             32'h0,         0, 32'h10,        32'h1000_000C, 32'hC,       1);
    add(0, 1, 0, 1, D,             32'h0,         0, 32'h10,        32'h1000_000C, 32'hC,       1);
    add(0, 1, 0, 1, D,             32'h0,         0, 32'h10,        32'h1000_000C, 32'hC,       1);
    add(0, 1, 0, 1, D,             32'h0,         0, 32'h10,        32'h1000_000C, 32'hC,       1);
    add(0, 1, 0, 0, 32'h1000_0010, 32'h0,         1, 32'h10,        32'h1000_000C, 32'hC,       1);
    // redirect while the memory is still waiting
    add(0, 0, 0, 0, D,             32'h0,         1, 32'h14,        32'h1000_0010, 32'h10,      1);
    add(0, 0, 1, 0, D,             32'h102,       1, 32'h14,        NOP,          32'h10,       0);
    add(0, 0, 0, 0, D,             32'h0,         1, 32'h14,        NOP,          32'h10,       0);
    add(0, 1, 0, 0, D,             32'h0,         1, 32'h14,        NOP,          32'h10,       0);
    add(0, 0, 0, 0, D,             32'h0,         1, 32'h100,       NOP,          32'h10,       0);
    add(0, 1, 0, 0, 32'h1000_0100, 32'h0,         1, 32'h100,       NOP,          32'h10,       0);
    // redirect in the same cycle as the response
    add(0, 0, 0, 0, D,             32'h0,         1, 32'h104,       32'h1000_0100, 32'h100,     1);
    add(0, 1, 1, 0, D,             32'h200,       1, 32'h104,       NOP,          32'h100,      0);
    add(0, 1, 0, 0, 32'h1000_0200, 32'h0,         1, 32'h200,       NOP,          32'h100,      0);
    add(0, 0, 0, 0, D,             32'h0,         1, 32'h204,       32'h1000_0200, 32'h200,     1);
    add(0, 1, 0, 0, 32'h1000_0204, 32'h0,         1, 32'h204,       NOP,          32'h200,      0);
    // redirect from IDLE suppresses the request that cycle; target is realigned
    add(0, 1, 1, 0, D,             32'hFFD,       0, 32'h208,       32'h1000_0204, 32'h204,     1);
    add(0, 1, 0, 0, 32'h1000_0FFC, 32'h0,         1, 32'hFFC,       NOP,          32'h204,      0);
    add(0, 0, 0, 0, D,             32'h0,         1, 32'h1000,      32'h1000_0FFC, 32'hFFC,     1);

    foreach (vecs[i]) begin
      @(negedge Clock);
      Reset = vecs[i].rst; Mem_Ready = vecs[i].ready; Branch_Taken = vecs[i].br;
      Stall = vecs[i].stall; Mem_Data = vecs[i].data; Branch_Target = vecs[i].tgt;
      #1;
      check($sformatf("row%0d Mem_Req", i),        {31'd0, Mem_Req},           {31'd0, vecs[i].req});
      check($sformatf("row%0d Mem_Addr", i),       Mem_Addr,                   vecs[i].addr);
      check($sformatf("row%0d Instruction", i),    Instruction,                vecs[i].instr);
      check($sformatf("row%0d Instruction_PC", i), Instruction_PC,             vecs[i].ipc);
      check($sformatf("row%0d Valid", i),          {31'd0, Instruction_Valid}, {31'd0, vecs[i].valid});
    end

    // Reset asserted while a request to 0x1000 is outstanding.
    @(negedge Clock);
    Mem_Ready = 1'b0; Branch_Taken = 1'b0; Stall = 1'b0;
    #1;
    check("midreq Mem_Req before reset", {31'd0, Mem_Req}, 32'd1);
    check("midreq Mem_Addr before reset", Mem_Addr, 32'h1000);
    #2 Reset = 1'b1;
    #1;
    check("midreq Mem_Req in reset", {31'd0, Mem_Req}, 32'd0);
    check("midreq Valid in reset", {31'd0, Instruction_Valid}, 32'd0);
    check("midreq Mem_Addr in reset", Mem_Addr, 32'h0);
    check("midreq Instruction in reset", Instruction, NOP);

    @(negedge Clock);
    Reset = 1'b0; Mem_Ready = 1'b1; Mem_Data = 32'h0A0A_0A0A; Stall = 1'b1;
    #1;
    check("restart Mem_Req", {31'd0, Mem_Req}, 32'd1);
    check("restart Mem_Addr", Mem_Addr, 32'h0);
    @(negedge Clock);
    #1;
    check("restart Valid", {31'd0, Instruction_Valid}, 32'd1);
    check("restart Instruction", Instruction, 32'h0A0A_0A0A);
    check("stall full no Mem_Req", {31'd0, Mem_Req}, 32'd0);
    // Reset with a full slot clears Valid before the next edge.
    #2 Reset = 1'b1;
    #1;
    check("full reset Valid", {31'd0, Instruction_Valid}, 32'd0);
    check("full reset Instruction_PC", Instruction_PC, 32'h0);

    // PC wraps from 0xFFFF_FFFC to 0.
    @(negedge Clock);
    Reset = 1'b0; Stall = 1'b0; Mem_Ready = 1'b0;
    Branch_Taken = 1'b1; Branch_Target = 32'hFFFF_FFFF;
    @(negedge Clock);
    Branch_Taken = 1'b0; Mem_Ready = 1'b1; Mem_Data = 32'h1234_5678;
    #1;
    check("wrap Mem_Addr top", Mem_Addr, 32'hFFFF_FFFC);
    @(negedge Clock);
    Mem_Ready = 1'b0;
    #1;
    check("wrap Mem_Addr zero", Mem_Addr, 32'h0);
    check("wrap Instruction_PC", Instruction_PC, 32'hFFFF_FFFC);
    check("wrap Instruction", Instruction, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
